// File: rtl/shift_add_control.sv
// Control FSM for a sequential shift-and-add multiplier: Load once, then Ad/Sh per bit, then Done.
// Optional macro SHIFT_ADD_DONE_HOLD_EN keeps the done state (Done=1) while St stays high.
module shift_add_control (
  input  logic Clk,
  input  logic Rst,
  input  logic St,
  input  logic M,
  input  logic K,
  output logic Load,
  output logic Ad,
  output logic Sh,
  output logic Done,
  output logic Idle
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // State register, asynchronously forced to idle
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

  // Mealy next-state and outputs; reset masks outputs so a held St cannot pulse Load
  always_comb begin
    w_next = r_state;
    Load   = 1'b0;
    Ad     = 1'b0;
    Sh     = 1'b0;
    Done   = 1'b0;
    Idle   = 1'b0;
    if (Rst) begin
      w_next = S0;
      Idle   = 1'b1;
    end else begin
      case (r_state)
        S0: begin
          Idle = 1'b1;
          if (St) begin
            Load   = 1'b1;
            w_next = S1;
          end else begin
            w_next = S0;
          end
        end
        S1: begin
          if (M) begin
            Ad     = 1'b1;
            w_next = S2;
          end else begin
            Sh     = 1'b1;
            w_next = K ? S3 : S1;
          end
        end
        S2: begin
          Sh     = 1'b1;
          w_next = K ? S3 : S1;
        end
        S3: begin
          Done = 1'b1;
`ifdef SHIFT_ADD_DONE_HOLD_EN
          w_next = St ? S3 : S0;
`else
          w_next = S0;
`endif
        end
        default: begin
          w_next = S0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_control.sv
// Scoreboard bench for shift_add_control: expected {Load,Ad,Sh,Done,Idle} queued per driven cycle.
module tb_shift_add_control;

  logic Clk = 1'b0;
  logic Rst;
  logic St;
  logic M;
  logic K;
  logic Load;
  logic Ad;
  logic Sh;
  logic Done;
  logic Idle;
  logic [4:0] obs;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] exp_q[$];

  localparam logic [4:0] E_IDLE = 5'b00001;
  localparam logic [4:0] E_LOAD = 5'b10001;
  localparam logic [4:0] E_AD   = 5'b01000;
  localparam logic [4:0] E_SH   = 5'b00100;
  localparam logic [4:0] E_DONE = 5'b00010;

  always #5 Clk = ~Clk;

  assign obs = {Load, Ad, Sh, Done, Idle};

  shift_add_control dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .St   (St),
    .M    (M),
    .K    (K),
    .Load (Load),
    .Ad   (Ad),
    .Sh   (Sh),
    .Done (Done),
    .Idle (Idle)
  );

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got {L,A,S,D,I}=%b expected %b", tag, got, want);
    end
  endtask

  // Drive one cycle's inputs, queue its expectation, compare mid-cycle
  task automatic step(input string tag, input logic st, input logic m, input logic k,
                      input logic [4:0] e);
    @(posedge Clk);
    #1;
    St = st;
    M  = m;
    K  = k;
    exp_q.push_back(e);
    @(negedge Clk);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  initial begin
    Rst = 1'b1;
    St  = 1'b0;
    M   = 1'b0;
    K   = 1'b0;
    #2;
    chk("rst_idle", obs, E_IDLE);
    St = 1'b1;
    M  = 1'b1;
    K  = 1'b1;
    #2;
    chk("rst_mask", obs, E_IDLE);
    #8;
    Rst = 1'b0;
    St  = 1'b0;
    M   = 1'b0;
    K   = 1'b0;
    #1;
    chk("post_rst", obs, E_IDLE);

    step("s0_noise", 1'b0, 1'b1, 1'b1, E_IDLE);
    step("t2_load",  1'b1, 1'b0, 1'b0, E_LOAD);
    step("t3_ad",    1'b0, 1'b1, 1'b0, E_AD);
    step("t3_sh",    1'b0, 1'b0, 1'b0, E_SH);
    step("t4_sh",    1'b0, 1'b0, 1'b1, E_SH);
    step("t4_done",  1'b0, 1'b0, 1'b0, E_DONE);
    step("t4_idle",  1'b0, 1'b0, 1'b0, E_IDLE);

    // multiplier 1011, LSB first; St pulses while busy must be ignored
    step("t5_load",  1'b1, 1'b0, 1'b0, E_LOAD);
    step("t5_ad0",   1'b0, 1'b1, 1'b0, E_AD);
    step("t5_sh0",   1'b1, 1'b0, 1'b0, E_SH);
    step("t5_ad1",   1'b0, 1'b1, 1'b0, E_AD);
    step("t5_sh1",   1'b0, 1'b0, 1'b0, E_SH);
    step("t5_sh2",   1'b1, 1'b0, 1'b0, E_SH);
    step("t5_ad3",   1'b0, 1'b1, 1'b1, E_AD);
    step("t5_sh3",   1'b0, 1'b0, 1'b1, E_SH);
    step("t5_done",  1'b0, 1'b0, 1'b0, E_DONE);
    step("t5_idle",  1'b0, 1'b0, 1'b0, E_IDLE);

    step("t6_load",  1'b1, 1'b0, 1'b1, E_LOAD);
    step("t6_sh",    1'b1, 1'b0, 1'b1, E_SH);
    step("t6_done",  1'b1, 1'b0, 1'b0, E_DONE);
`ifdef SHIFT_ADD_DONE_HOLD_EN
    step("t6_hold",  1'b1, 1'b0, 1'b0, E_DONE);
    step("t6_drop",  1'b0, 1'b0, 1'b0, E_DONE);
    step("t6_idle",  1'b0, 1'b0, 1'b0, E_IDLE);
`else
    step("t6_reload", 1'b1, 1'b0, 1'b0, E_LOAD);
    step("t6_sh2",    1'b0, 1'b0, 1'b1, E_SH);
    step("t6_done2",  1'b0, 1'b0, 1'b0, E_DONE);
    step("t6_idle",   1'b0, 1'b0, 1'b0, E_IDLE);
`endif

    // abort from S2 with K=1: no Done may follow
    step("m_load", 1'b1, 1'b0, 1'b0, E_LOAD);
    step("m_ad",   1'b0, 1'b1, 1'b0, E_AD);
    @(posedge Clk);
    #1;
    St = 1'b0;
    M  = 1'b0;
    K  = 1'b1;
    #1;
    chk("m_sh", obs, E_SH);
    #2;
    Rst = 1'b1;
    #1;
    chk("m_abort", obs, E_IDLE);
    @(posedge Clk);
    #1;
    chk("m_hold", obs, E_IDLE);
    Rst = 1'b0;
    K   = 1'b0;
    step("m_nodone", 1'b0, 1'b0, 1'b0, E_IDLE);
    step("m_restart", 1'b1, 1'b0, 1'b0, E_LOAD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
